// File: rtl/bus_loader.sv
// Bus initiator: loads port words into consecutive memory addresses, or dumps memory words to a port.
// Bus requests are held until ready is sampled; port_out is held until port_ack; load words wait in a small FIFO.
module bus_loader #(
  parameter int fifo_addr = 2,
  parameter int fifo_size = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic [15:0] base,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  input  logic        ready,
  output logic        read,
  output logic        write,
  output logic [15:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        port_write,
  input  logic [15:0] port_in,
  output logic        port_valid,
  input  logic        port_ack,
  output logic [15:0] port_out
);

  typedef enum logic [2:0] {IDLE, L_WAIT, L_WRITE, D_READ, D_OUT, FIN} state_t;

  state_t      state, state_d;
  logic [15:0] addr, addr_d, remaining, remaining_d;
  logic        dir_r, dir_d;
  logic        busy_d, done_d, overflow_d, read_d, write_d, port_valid_d;
  logic [15:0] address_d, data_out_d, port_out_d;

  logic [15:0]          fifo_mem [fifo_size];
  logic [fifo_addr-1:0] wr_ptr, rd_ptr;
  logic [fifo_addr:0]   fifo_cnt;
  logic                 fifo_empty, fifo_full, push_req, push, pop, accept;

  // Depth is a power of two, so the count MSB alone marks full.
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = fifo_cnt[fifo_addr];
  assign accept     = start && (state == IDLE) && !busy;
  assign push_req   = port_write && busy && !dir_r;
  assign pop        = (state == L_WAIT) && !fifo_empty;
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    state_d      = state;
    addr_d       = addr;
    remaining_d  = remaining;
    dir_d        = dir_r;
    busy_d       = busy;
    done_d       = 1'b0;
    read_d       = read;
    write_d      = write;
    address_d    = address;
    data_out_d   = data_out;
    port_valid_d = port_valid;
    port_out_d   = port_out;
    overflow_d   = overflow;
    if (accept)
      overflow_d = 1'b0;
    else if (push_req && fifo_full && !pop)
      overflow_d = 1'b1;

    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          busy_d      = 1'b1;
          addr_d      = base;
          remaining_d = count;
          dir_d       = dir;
          if (count == 16'd0) begin
            state_d = FIN;
          end else if (dir) begin
            state_d   = D_READ;
            read_d    = 1'b1;
            address_d = base;
          end else begin
            state_d = L_WAIT;
          end
        end
      end
      L_WAIT: begin
        if (pop) begin
          data_out_d = fifo_mem[rd_ptr];
          address_d  = addr;
          write_d    = 1'b1;
          state_d    = L_WRITE;
        end
      end
      L_WRITE: begin
        if (ready) begin
          write_d     = 1'b0;
          addr_d      = addr + 16'd1;
          remaining_d = remaining - 16'd1;
          if (remaining == 16'd1) state_d = FIN;
          else                    state_d = L_WAIT;
        end
      end
      D_READ: begin
        if (ready) begin
          read_d       = 1'b0;
          port_out_d   = data_in;
          port_valid_d = 1'b1;
          state_d      = D_OUT;
        end
      end
      D_OUT: begin
        if (port_ack) begin
          port_valid_d = 1'b0;
          addr_d       = addr + 16'd1;
          remaining_d  = remaining - 16'd1;
          if (remaining == 16'd1) begin
            state_d = FIN;
          end else begin
            state_d   = D_READ;
            read_d    = 1'b1;
            address_d = addr + 16'd1;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      dir_r      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      port_valid <= 1'b0;
      address    <= '0;
      data_out   <= '0;
      port_out   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      state      <= state_d;
      addr       <= addr_d;
      remaining  <= remaining_d;
      dir_r      <= dir_d;
      busy       <= busy_d;
      done       <= done_d;
      overflow   <= overflow_d;
      read       <= read_d;
      write      <= write_d;
      port_valid <= port_valid_d;
      address    <= address_d;
      data_out   <= data_out_d;
      port_out   <= port_out_d;
      if (accept) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + fifo_addr'(1);
        if (pop)  rd_ptr <= rd_ptr + fifo_addr'(1);
        if (push && !pop)
          fifo_cnt <= fifo_cnt + (fifo_addr + 1)'(1);
        else if (pop && !push)
          fifo_cnt <= fifo_cnt - (fifo_addr + 1)'(1);
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= port_in;
  end

endmodule

// File: tb/tb_bus_loader.sv
// Directed bench for bus_loader: a negedge monitor acts as bus responder and port consumer,
// popping expected writes, read addresses, port words and done pulses from scoreboard queues.
module tb_bus_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] base = '0;
  logic [15:0] count = '0;
  logic        busy, done, overflow, read, write, port_valid;
  logic        ready = 1'b0;
  logic [15:0] address, data_out, port_out;
  logic [15:0] data_in = '0;
  logic        port_write = 1'b0;
  logic [15:0] port_in = '0;
  logic        port_ack = 1'b0;

  bus_loader dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .base(base), .count(count),
    .busy(busy), .done(done), .overflow(overflow), .ready(ready), .read(read),
    .write(write), .address(address), .data_in(data_in), .data_out(data_out),
    .port_write(port_write), .port_in(port_in), .port_valid(port_valid),
    .port_ack(port_ack), .port_out(port_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] exp_port[$];
  int          exp_done = 0;
  logic [15:0] mem_model [logic [15:0]];

  int          resp_delay = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          ack_cnt = 0;
  logic        in_req = 1'b0;
  logic [15:0] req_addr, req_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  // Responder, consumer and monitor share one negedge process so their decisions agree.
  always @(negedge clk) begin
    if (!reset) begin
      ready = 1'b0;
      port_ack = 1'b0;
      wait_cnt = 0;
      ack_cnt = 0;
      in_req = 1'b0;
    end else begin
      if ((read || write) && !ready) begin
        check("rw_exclusive", {31'b0, read && write}, 32'd0);
        if (in_req) begin
          check("req_addr_stable", {16'b0, address}, {16'b0, req_addr});
          if (write) check("req_data_stable", {16'b0, data_out}, {16'b0, req_data});
        end else begin
          in_req = 1'b1;
          req_addr = address;
          req_data = data_out;
        end
        if (wait_cnt >= resp_delay) begin
          ready = 1'b1;
          wait_cnt = 0;
          in_req = 1'b0;
          if (write) begin
            if (exp_wr.size() == 0) fail_now("unexpected_write", $sformatf("addr %h data %h", address, data_out));
            else begin
              logic [31:0] e;
              e = exp_wr.pop_front();
              check("wr_addr", {16'b0, address}, {16'b0, e[31:16]});
              check("wr_data", {16'b0, data_out}, {16'b0, e[15:0]});
            end
          end else begin
            data_in = mem_model.exists(address) ? mem_model[address] : 16'h0000;
            if (exp_rd.size() == 0) fail_now("unexpected_read", $sformatf("addr %h", address));
            else check("rd_addr", {16'b0, address}, {16'b0, exp_rd.pop_front()});
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        ready = 1'b0;
        in_req = 1'b0;
        wait_cnt = 0;
      end

      if (port_valid && !port_ack) begin
        if (exp_port.size() == 0) begin
          fail_now("unexpected_port", $sformatf("port_out %h", port_out));
          port_ack = 1'b1;
        end else if (ack_cnt >= ack_delay) begin
          port_ack = 1'b1;
          ack_cnt = 0;
          check("port_word", {16'b0, port_out}, {16'b0, exp_port.pop_front()});
        end else begin
          ack_cnt++;
          check("port_hold", {16'b0, port_out}, {16'b0, exp_port[0]});
        end
      end else begin
        port_ack = 1'b0;
      end

      if (done) begin
        if (exp_done == 0) fail_now("unexpected_done", "done pulsed");
        else begin
          exp_done--;
          check("busy_at_done", {31'b0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic do_start(input logic d, input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    dir = d;
    base = b;
    count = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    @(negedge clk);
    port_write = 1'b1;
    port_in = w;
    @(negedge clk);
    port_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_done != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b pending_done=%0d after %0d cycles", name, busy, exp_done, n);
    end
    check({name, "_wr_left"}, exp_wr.size(), 32'd0);
    check({name, "_rd_left"}, exp_rd.size(), 32'd0);
    check({name, "_port_left"}, exp_port.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w [6];

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_read", {31'b0, read}, 32'd0);
    check("rst_write", {31'b0, write}, 32'd0);
    check("rst_port_valid", {31'b0, port_valid}, 32'd0);
    check("rst_address", {16'b0, address}, 32'd0);
    check("rst_data_out", {16'b0, data_out}, 32'd0);
    check("rst_port_out", {16'b0, port_out}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Load 3 words, fast responder
    resp_delay = 0;
    exp_wr.push_back({16'h0400, 16'h1111});
    exp_wr.push_back({16'h0401, 16'h2222});
    exp_wr.push_back({16'h0402, 16'h3333});
    exp_done = 1;
    do_start(1'b0, 16'h0400, 16'd3);
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    wait_idle("load3", 200);
    check("load3_busy_low", {31'b0, busy}, 32'd0);
    check("load3_overflow", {31'b0, overflow}, 32'd0);

    // Load 2 words with a slow responder
    resp_delay = 5;
    exp_wr.push_back({16'h1000, 16'hA5A5});
    exp_wr.push_back({16'h1001, 16'h5A5A});
    exp_done = 1;
    do_start(1'b0, 16'h1000, 16'd2);
    push_word(16'hA5A5);
    push_word(16'h5A5A);
    wait_idle("slow", 200);

    // Overflow: the first word is popped into data_out before the stall,
    // the next four fill the FIFO and the sixth is dropped.
    resp_delay = 30;
    for (int i = 0; i < 6; i++) w[i] = 16'h0101 * 16'(i + 1);
    for (int i = 0; i < 5; i++) exp_wr.push_back({16'h2000 + 16'(i), w[i]});
    exp_wr.push_back({16'h2005, 16'h0707});
    exp_wr.push_back({16'h2006, 16'h0808});
    exp_wr.push_back({16'h2007, 16'h0909});
    exp_done = 1;
    do_start(1'b0, 16'h2000, 16'd8);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      port_write = 1'b1;
      port_in = w[i];
    end
    @(negedge clk);
    port_write = 1'b0;
    check("ovf_set", {31'b0, overflow}, 32'd1);
    resp_delay = 0;
    repeat (40) @(negedge clk);
    check("ovf_waiting_words", exp_wr.size(), 32'd3);
    check("ovf_still_busy", {31'b0, busy}, 32'd1);
    check("ovf_no_write", {31'b0, write}, 32'd0);
    push_word(16'h0707);
    push_word(16'h0808);
    push_word(16'h0909);
    wait_idle("ovf", 200);
    check("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Dump across the address wrap, delayed acks, ignored start while busy
    resp_delay = 1;
    ack_delay = 3;
    mem_model[16'hfffe] = 16'hAAAA;
    mem_model[16'hffff] = 16'hBBBB;
    mem_model[16'h0000] = 16'hCCCC;
    exp_rd.push_back(16'hfffe);
    exp_rd.push_back(16'hffff);
    exp_rd.push_back(16'h0000);
    exp_port.push_back(16'hAAAA);
    exp_port.push_back(16'hBBBB);
    exp_port.push_back(16'hCCCC);
    exp_done = 1;
    do_start(1'b1, 16'hfffe, 16'd3);
    check("dump_ovf_cleared", {31'b0, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    do_start(1'b0, 16'h5555, 16'd7);
    wait_idle("dump", 300);
    ack_delay = 0;

    // Zero count: done two cycles after start, no bus traffic
    resp_delay = 0;
    exp_done = 1;
    @(negedge clk);
    dir = 1'b0;
    count = 16'd0;
    base = 16'h7000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_busy_c1", {31'b0, busy}, 32'd1);
    check("zero_done_c1", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("zero_done_c2", {31'b0, done}, 32'd1);
    @(negedge clk);
    check("zero_busy_c3", {31'b0, busy}, 32'd0);
    check("zero_done_c3", {31'b0, done}, 32'd0);
    wait_idle("zero", 20);

    // Reset in the middle of a stalled read
    resp_delay = 1000;
    do_start(1'b1, 16'h3000, 16'd4);
    check("mid_read_high", {31'b0, read}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_read", {31'b0, read}, 32'd0);
    check("abort_port_valid", {31'b0, port_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_address", {16'b0, address}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_read_after", {31'b0, read}, 32'd0);
    check("abort_busy_after", {31'b0, busy}, 32'd0);
    check("abort_done_after", {31'b0, done}, 32'd0);
    resp_delay = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
